hacd_cfg_regfile: RTL and testbench

Register-interface responder that terminates the 32-bit `reg_intf` request stream produced by the HACD AXI-lite front end. It holds the HACD control, status and event-count registers and raises the inflate/deflate interrupt lines toward the core. Reads return data in the same cycle as the accepted request. Every accepted write costs one commit cycle with `resp_ready_o` low.

---
 rtl/hacd_cfg_regfile.sv | 221 ++++++++++++++++++++++
 tb/tb_hacd_cfg_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hacd_cfg_regfile.sv
// hacd_cfg_regfile: register-interface responder for the HACD block.
// Holds ID, CTRL, STATUS (W1C), optional event counters and SCRATCH, and
// drives the registered inflate/deflate interrupt levels.
// Reads complete combinationally in the accept cycle. Each accepted write
// costs one COMMIT cycle with resp_ready_o low.
// Optional feature macro: HACD_CFG_EVCNT_EN adds the INFL_CNT/DEFL_CNT
// counters at 0x0C/0x10. Without it those offsets decode as unmapped.
module hacd_cfg_regfile #(
  parameter logic [31:0] HacdId     = 32'h4841_4344,
  parameter int unsigned EvCntWidth = 32
) (
  input  logic        cfg_clk_i,
  input  logic        cfg_rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_ready_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_error_o,
  input  logic        infl_event_i,
  input  logic        defl_event_i,
  output logic        hacd_enable_o,
  output logic        infl_interrupt_o,
  output logic        defl_interrupt_o
);

  typedef enum logic {
    ST_READY  = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  localparam logic [5:0] W_ID      = 6'd0;
  localparam logic [5:0] W_CTRL    = 6'd1;
  localparam logic [5:0] W_STATUS  = 6'd2;
  localparam logic [5:0] W_INFL    = 6'd3;
  localparam logic [5:0] W_DEFL    = 6'd4;
  localparam logic [5:0] W_SCRATCH = 6'd5;

  state_e      state_q, state_d;

  // CTRL: [0] enable, [1] infl_irq_en, [2] defl_irq_en
  logic [2:0]  ctrl_q, ctrl_d;
  // STATUS: [0] infl_pend, [1] defl_pend
  logic [1:0]  pend_q, pend_d;
  logic [31:0] scratch_q, scratch_d;
  logic        infl_irq_q, defl_irq_q;

  logic        sel_id, sel_ctrl, sel_status, sel_infl, sel_defl, sel_scratch;
  logic        mapped;
  logic        accept, wr_acc;
  logic        infl_ev, defl_ev;
  logic [31:0] rd_mux;
  logic [5:0]  word;
  logic        unused_addr_lsb;

  assign word            = req_addr_i[7:2];
  // The byte lane inside a word is irrelevant: all registers are 32-bit.
  assign unused_addr_lsb = ^req_addr_i[1:0];

  assign accept  = req_valid_i && resp_ready_o;
  assign wr_acc  = accept && req_write_i;
  // Events only count while the block is enabled.
  assign infl_ev = infl_event_i && ctrl_q[0];
  assign defl_ev = defl_event_i && ctrl_q[0];

  // Byte-lane merge for strobed RW registers.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Address decode: only the low 256 bytes are mapped.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    sel_id      = 1'b0;
    sel_ctrl    = 1'b0;
    sel_status  = 1'b0;
    sel_infl    = 1'b0;
    sel_defl    = 1'b0;
    sel_scratch = 1'b0;
    if (req_addr_i[31:8] == 24'd0) begin
      case (word)
        W_ID:      sel_id      = 1'b1;
        W_CTRL:    sel_ctrl    = 1'b1;
        W_STATUS:  sel_status  = 1'b1;
`ifdef HACD_CFG_EVCNT_EN
        W_INFL:    sel_infl    = 1'b1;
        W_DEFL:    sel_defl    = 1'b1;
`endif
        W_SCRATCH: sel_scratch = 1'b1;
        default:   ;
      endcase
    end
  end

  assign mapped = sel_id | sel_ctrl | sel_status | sel_infl | sel_defl | sel_scratch;

  // Next value of CTRL, STATUS and SCRATCH from software writes and events.
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    pend_d    = pend_q;
    if (wr_acc && sel_ctrl && req_wstrb_i[0]) ctrl_d = req_wdata_i[2:0];
    if (wr_acc && sel_scratch) scratch_d = strb_merge(scratch_q, req_wdata_i, req_wstrb_i);
    if (wr_acc && sel_status && req_wstrb_i[0]) pend_d = pend_q & ~req_wdata_i[1:0];
    // An event in the same cycle as a W1C wins: the pend bit stays set.
    pend_d = pend_d | {defl_ev, infl_ev};
  end

  // Software-visible register state.
  always_ff @(posedge cfg_clk_i or posedge cfg_rst_i) begin
    if (cfg_rst_i) begin
      ctrl_q    <= '0;
      pend_q    <= '0;
      scratch_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
      scratch_q <= scratch_d;
    end
  end

  // Interrupt levels are registered from the current pend/enable state.
  always_ff @(posedge cfg_clk_i or posedge cfg_rst_i) begin
    if (cfg_rst_i) begin
      infl_irq_q <= 1'b0;
      defl_irq_q <= 1'b0;
    end else begin
      infl_irq_q <= pend_q[0] & ctrl_q[1] & ctrl_q[0];
      defl_irq_q <= pend_q[1] & ctrl_q[2] & ctrl_q[0];
    end
  end

`ifdef HACD_CFG_EVCNT_EN
  logic [EvCntWidth-1:0] infl_cnt_q, infl_cnt_d;
  logic [EvCntWidth-1:0] defl_cnt_q, defl_cnt_d;
  logic [31:0]           infl_cnt_ext, defl_cnt_ext;

  // Counter next state: a write clears, then an event increments up to all-ones,
  // so clear plus event in the same cycle yields 1.
  always_comb begin
    infl_cnt_d = infl_cnt_q;
    defl_cnt_d = defl_cnt_q;
    if (wr_acc && sel_infl) infl_cnt_d = '0;
    if (wr_acc && sel_defl) defl_cnt_d = '0;
    if (infl_ev && (infl_cnt_d != '1)) infl_cnt_d = infl_cnt_d + EvCntWidth'(1);
    if (defl_ev && (defl_cnt_d != '1)) defl_cnt_d = defl_cnt_d + EvCntWidth'(1);
  end

  // Event counter flops.
  always_ff @(posedge cfg_clk_i or posedge cfg_rst_i) begin
    if (cfg_rst_i) begin
      infl_cnt_q <= '0;
      defl_cnt_q <= '0;
    end else begin
      infl_cnt_q <= infl_cnt_d;
      defl_cnt_q <= defl_cnt_d;
    end
  end

  // Zero-extend counters to the 32-bit read bus.
  always_comb begin
    infl_cnt_ext                   = '0;
    defl_cnt_ext                   = '0;
    infl_cnt_ext[EvCntWidth-1:0]   = infl_cnt_q;
    defl_cnt_ext[EvCntWidth-1:0]   = defl_cnt_q;
  end
`endif

  // Read data mux; unselected or unmapped words read as 0.
  always_comb begin
    rd_mux = '0;
    if (sel_id)      rd_mux = HacdId;
    if (sel_ctrl)    rd_mux = {29'd0, ctrl_q};
    if (sel_status)  rd_mux = {30'd0, pend_q};
    if (sel_scratch) rd_mux = scratch_q;
`ifdef HACD_CFG_EVCNT_EN
    if (sel_infl)    rd_mux = infl_cnt_ext;
    if (sel_defl)    rd_mux = defl_cnt_ext;
`endif
  end

  // FSM state register.
  always_ff @(posedge cfg_clk_i or posedge cfg_rst_i) begin
    if (cfg_rst_i) state_q <= ST_READY;
    else           state_q <= state_d;
  end

  // FSM next state: an accepted write spends one cycle in COMMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY:  if (wr_acc) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_READY;
      default:   state_d = ST_READY;
    endcase
  end

  // FSM and response outputs.
  always_comb begin
    resp_ready_o = (state_q == ST_READY);
    resp_rdata_o = (req_valid_i && !req_write_i) ? rd_mux : 32'd0;
    resp_error_o = req_valid_i && !mapped;
  end

  assign hacd_enable_o    = ctrl_q[0];
  assign infl_interrupt_o = infl_irq_q;
  assign defl_interrupt_o = defl_irq_q;

endmodule

// File: tb/tb_hacd_cfg_regfile.sv
// tb_hacd_cfg_regfile: directed self-checking bench for hacd_cfg_regfile.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_hacd_cfg_regfile;

  localparam logic [31:0] ID = 32'h4841_4344;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        infl_event;
  logic        defl_event;
  logic        hacd_enable;
  logic        infl_irq;
  logic        defl_irq;

  int n_cmp = 0;
  int n_bad = 0;

  hacd_cfg_regfile #(
    .HacdId     (ID),
    .EvCntWidth (32)
  ) dut (
    .cfg_clk_i        (clk),
    .cfg_rst_i        (rst),
    .req_valid_i      (req_valid),
    .req_write_i      (req_write),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .req_wstrb_i      (req_wstrb),
    .resp_ready_o     (resp_ready),
    .resp_rdata_o     (resp_rdata),
    .resp_error_o     (resp_error),
    .infl_event_i     (infl_event),
    .defl_event_i     (defl_event),
    .hacd_enable_o    (hacd_enable),
    .infl_interrupt_o (infl_irq),
    .defl_interrupt_o (defl_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read in READY: check combinational response, then let the accept edge pass.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d,
                    input logic exp_e, input string tag);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    #1;
    check({tag, "_rdata"}, resp_rdata, exp_d);
    check({tag, "_err"},   resp_error, exp_e);
    check({tag, "_rdy"},   resp_ready, 1);
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
  endtask

  // Present a write and let the accept edge pass; the DUT is then in COMMIT.
  task automatic wr_start(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic exp_e, input string tag);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_wstrb = strb;
    #1;
    check({tag, "_werr"}, resp_error, exp_e);
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
  endtask

  task automatic wr_end(input string tag);
    check({tag, "_commit_rdy"}, resp_ready, 0);
    tick();
    check({tag, "_after_rdy"}, resp_ready, 1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic exp_e, input string tag);
    wr_start(addr, data, strb, exp_e, tag);
    wr_end(tag);
  endtask

  task automatic pulse(input logic infl, input logic defl);
    infl_event = infl;
    defl_event = defl;
    tick();
    infl_event = 1'b0;
    defl_event = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    infl_event = 1'b0;
    defl_event = 1'b0;

    // Outputs while in reset
    #3;
    check("rst_ready",  resp_ready,  1);
    check("rst_rdata",  resp_rdata,  0);
    check("rst_error",  resp_error,  0);
    check("rst_enable", hacd_enable, 0);
    check("rst_iirq",   infl_irq,    0);
    check("rst_dirq",   defl_irq,    0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    rd(32'h00, ID, 0, "id");
    check("id_enable", hacd_enable, 0);

    // Enable everything
    wr(32'h04, 32'h7, 4'hF, 0, "ctrl7");
    check("ctrl7_enable", hacd_enable, 1);
    rd(32'h04, 32'h7, 0, "ctrl_rd");

    // Inflate event: pend sets, interrupt follows one cycle later
    pulse(1, 0);
    check("infl_irq_lag", infl_irq, 0);
    rd(32'h08, 32'h1, 0, "stat_infl");
    check("infl_irq_up", infl_irq, 1);
`ifdef HACD_CFG_EVCNT_EN
    rd(32'h0C, 32'h1, 0, "infl_cnt1");
`endif
    wr_start(32'h08, 32'h1, 4'hF, 0, "w1c_infl");
    check("infl_irq_hold", infl_irq, 1);
    wr_end("w1c_infl");
    check("infl_irq_down", infl_irq, 0);
    rd(32'h08, 32'h0, 0, "stat_clr");

    // Deflate event, then W1C racing a second event: bit stays set
    pulse(0, 1);
    check("defl_irq_lag", defl_irq, 0);
    rd(32'h08, 32'h2, 0, "stat_defl");
    defl_event = 1'b1;
    wr_start(32'h08, 32'h2, 4'hF, 0, "w1c_race");
    defl_event = 1'b0;
    wr_end("w1c_race");
    rd(32'h08, 32'h2, 0, "stat_race");
    check("defl_irq_race", defl_irq, 1);
`ifdef HACD_CFG_EVCNT_EN
    rd(32'h10, 32'h2, 0, "defl_cnt2");
    defl_event = 1'b1;
    wr_start(32'h10, 32'h0, 4'hF, 0, "cnt_race");
    defl_event = 1'b0;
    wr_end("cnt_race");
    rd(32'h10, 32'h1, 0, "defl_cnt_race");
`else
    rd(32'h0C, 32'h0, 1, "infl_cnt_unmap");
    rd(32'h10, 32'h0, 1, "defl_cnt_unmap");
`endif

    // W1C ignored without byte-lane 0, honoured with it
    wr(32'h08, 32'h2, 4'hE, 0, "w1c_nostrb");
    rd(32'h08, 32'h2, 0, "stat_nostrb");
    wr(32'h08, 32'h2, 4'hF, 0, "w1c_defl");
    check("defl_irq_down", defl_irq, 0);

    // Disable: events ignored, and CTRL honours byte strobes
    wr(32'h04, 32'h6, 4'hF, 0, "ctrl6");
    check("ctrl6_enable", hacd_enable, 0);
    pulse(1, 1);
    rd(32'h08, 32'h0, 0, "stat_disabled");
`ifdef HACD_CFG_EVCNT_EN
    rd(32'h0C, 32'h1, 0, "infl_cnt_dis");
`endif
    wr(32'h04, 32'h7, 4'hE, 0, "ctrl_nostrb");
    rd(32'h04, 32'h6, 0, "ctrl_keep");

    // SCRATCH with byte strobes, and addr[1:0] ignored
    wr(32'h14, 32'hFFFF_FFFF, 4'hF, 0, "scr_ones");
    wr(32'h14, 32'h1234_5678, 4'h5, 0, "scr_part");
    rd(32'h17, 32'hFF34_FF78, 0, "scr_rd");

    // Unmapped accesses and RO ID write
    rd(32'h40,  32'h0, 1, "unmap_rd40");
    rd(32'h18,  32'h0, 1, "unmap_rd18");
    wr(32'h100, 32'h5555_5555, 4'hF, 1, "unmap_w100");
    wr(32'h114, 32'h0, 4'hF, 1, "unmap_w114");
    wr(32'h104, 32'h7, 4'hF, 1, "unmap_w104");
    wr(32'h00,  32'h0, 4'hF, 0, "id_wr");
    rd(32'h14,  32'hFF34_FF78, 0, "scr_intact");
    rd(32'h04,  32'h6, 0, "ctrl_intact");
    rd(32'h00,  ID, 0, "id_intact");

    // Reset during COMMIT
    wr_start(32'h14, 32'hDEAD_BEEF, 4'hF, 0, "scr_beef");
    check("beef_commit_rdy", resp_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", resp_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_ready", resp_ready, 1);
    rd(32'h14, 32'h0, 0, "scr_postrst");
    rd(32'h04, 32'h0, 0, "ctrl_postrst");
    check("postrst_enable", hacd_enable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
